// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch, PC register and next-PC steering for the single-cycle MIPS datapath
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCenable,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        selectRegorJump,
    input  logic        Zero,
    input  logic [31:0] RegRs,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic [5:0]  Op,
    output logic [5:0]  Funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm16,
    output logic [25:0] target26,
    output logic [31:0] PCplus4,
    output logic        instr_valid,
    output logic        halted,
    output logic        align_fault
);

    typedef enum logic [2:0] {
        S_BOOT  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [5:0] OP_DONE = 6'h3f;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_align_fault;
    logic [31:0] w_pcplus4;
    logic [31:0] w_branch_off;
    logic [31:0] w_pc_next;
    logic        w_set_fault;

    assign w_pcplus4    = r_pc + 32'd4;
    assign w_branch_off = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

    assign imem_addr   = r_pc;
    assign Instr       = r_instr;
    assign Op          = r_instr[31:26];
    assign Funct       = r_instr[5:0];
    assign rs          = r_instr[25:21];
    assign rt          = r_instr[20:16];
    assign rd          = r_instr[15:11];
    assign imm16       = r_instr[15:0];
    assign target26    = r_instr[25:0];
    assign PCplus4     = w_pcplus4;
    assign align_fault = r_align_fault;

    // State register; reset forces BOOT so imem_req drops without waiting for a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_next_state = r_state;
        imem_req     = 1'b0;
        instr_valid  = 1'b0;
        halted       = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_next_state = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                instr_valid = 1'b1;
                if (r_instr[31:26] == OP_DONE) begin
                    w_next_state = S_HALT;
                end else begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                instr_valid  = 1'b1;
                w_next_state = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_next_state = S_BOOT;
            end
        endcase
    end

    // Next-PC selection; only consulted in EXEC, when the decoder outputs are current
    always_comb begin
        w_pc_next   = w_pcplus4;
        w_set_fault = 1'b0;
        if (!PCenable) begin
            w_pc_next = r_pc;
        end else if (Jump && selectRegorJump) begin
            w_pc_next   = {RegRs[31:2], 2'b00};
            w_set_fault = (RegRs[1:0] != 2'b00);
        end else if (Jump) begin
            w_pc_next = {w_pcplus4[31:28], r_instr[25:0], 2'b00};
        end else if (Branch && !Zero) begin
            w_pc_next = w_pcplus4 + w_branch_off;
        end
    end

    // PC, instruction latch and sticky alignment fault
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_instr       <= 32'h0;
            r_align_fault <= 1'b0;
        end else begin
            if (r_state == S_FETCH && imem_ack) begin
                r_instr <= imem_rdata;
            end
            if (r_state == S_EXEC) begin
                r_pc <= w_pc_next;
                if (w_set_fault) begin
                    r_align_fault <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch and next-PC unit for the single-cycle MIPS datapath. It is the producer of the instruction fields the control decoder consumes (Op, Funct, rs, rt, rd, imm16, target26) and the consumer of that decoder's PC-steering outputs (PCenable, Branch, Jump, selectRegorJump). It owns the PC register, runs a request/acknowledge handshake to instruction memory, and halts on the `done` opcode (6'h3f).

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- clk  input  1  system clock, all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- PCenable  input  1  from the control decoder; 0 = hold PC this instruction.
- Branch  input  1  from the control decoder; bne in flight.
- Jump  input  1  from the control decoder; j, jal or jr in flight.
- selectRegorJump  input  1  from the control decoder; 1 = jump target is RegRs (jr).
- Zero  input  1  ALU zero flag for the current instruction.
- RegRs  input  32  R[rs] from the register file (jr target).
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  byte address of the fetch, equal to PC.
- imem_ack  input  1  memory has placed valid data on imem_rdata.
- imem_rdata  input  32  instruction word.
- Instr  output  32  latched instruction.
- Op, Funct  output  6 each  Instr[31:26], Instr[5:0].
- rs, rt, rd  output  5 each  Instr[25:21], [20:16], [15:11].
- imm16  output  16  Instr[15:0].
- target26  output  26  Instr[25:0].
- PCplus4  output  32  PC + 4 (mod 2^32), for the jal link path.
- instr_valid  output  1  instruction fields are valid for the decoder.
- halted  output  1  done opcode reached.
- align_fault  output  1  sticky; jr target had nonzero bits [1:0].

## Operation
- States: BOOT, FETCH, ISSUE, EXEC, HALT.
- BOOT: entered on reset; leaves for FETCH on the next clock edge.
- FETCH: imem_req=1 and imem_addr=PC, both held stable until imem_ack. On the edge where imem_ack=1, Instr<=imem_rdata and the FSM moves to ISSUE. imem_ack outside FETCH is ignored.
- ISSUE: instr_valid=1. The decoder registers its outputs on this edge. If Op==6'h3f, move to HALT; otherwise move to EXEC.
- EXEC: instr_valid=1, and the decoder outputs are valid. PC update on the exit edge, in priority order:
  - PCenable=0: PC holds.
  - Jump=1, selectRegorJump=1: PC <= {RegRs[31:2],2'b00}. align_fault is set if RegRs[1:0]!=0.
  - Jump=1, selectRegorJump=0: PC <= {PCplus4[31:28],target26,2'b00}.
  - Branch=1 and Zero=0 (bne taken): PC <= PCplus4 + {{14{imm16[15]}},imm16,2'b00}, modulo 2^32.
  - Otherwise: PC <= PCplus4.
- EXEC always returns to FETCH.
- HALT: terminal. PC, Instr and align_fault frozen; imem_req=0; halted=1. Only reset exits HALT.
- Arithmetic: all PC adds are 32-bit and wrap. 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset values (applied asynchronously): PC=RESET_PC, Instr=0, state=BOOT, imem_req=0, instr_valid=0, halted=0, align_fault=0.
- Reset asserted mid-fetch drops imem_req immediately, with no wait for a clock edge; a late imem_ack is ignored.
- Throughput: minimum 3 cycles per instruction when imem_ack arrives in the first FETCH cycle (FETCH, ISSUE, EXEC). Each wait cycle on imem_ack adds one cycle.
- First imem_req is asserted on the first edge after reset deasserts, on leaving BOOT.
- instr_valid is high exactly during ISSUE and EXEC. Fields stay stable across both cycles.
- halted rises on the edge leaving ISSUE with Op==6'h3f and stays high until reset.
- Decoder outputs seen in ISSUE are stale and must not affect the PC. Only EXEC-cycle values are used.

## Test plan
- Reset with RESET_PC=0, memory ack in 0 cycles, memory holds add, add, add -> imem_addr sequence 0,4,8; each instr_valid pulse is 2 cycles wide, 3 cycles per instruction.
- PC=8, instr bne with imm16=16'hFFFE, Zero=0 in EXEC -> next imem_addr 4. Same case with Zero=1 -> next imem_addr 12.
- PC=32'h4000_0010, j with target26=26'h000_0040 -> next imem_addr 32'h4000_0100. jr with RegRs=32'h0000_0203 -> next imem_addr 32'h200 and align_fault=1.
- imem_ack delayed 3 cycles -> imem_req and imem_addr stay stable for 4 cycles, Instr is captured only on the ack edge, and a stray ack during EXEC is ignored.
- Fetch of 32'hFC00_0000 -> halted=1 two edges after the ack, imem_req stays 0 for over 10 cycles. Asserting reset then returns PC to RESET_PC with halted=0.
- Reset asserted mid-FETCH -> imem_req=0 within the same cycle. PC at 32'hFFFF_FFFC with a sequential instruction -> next imem_addr 0.
